// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter
// Shares the single memory port between the IFU fetch read, the EXEC operand
// read and the EXEC write. One transaction is in flight at a time: the
// winner's address/data are latched at grant, the memory strobe is driven for
// exactly one cycle, and read data or write completion is returned as a
// one-cycle pulse to the owning requester. Every output is a register.

module pdp8_mem_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [DATA_WIDTH-1:0] ifu_rd_data,
   output logic                  ifu_rd_valid,

   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  exec_rd_valid,

   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  exec_wr_done,

   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,

   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,

   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_RESP,
      WR_ISSUE,
      WR_RESP
   } state_t;

   // Identifies one of the two read requesters.
   typedef enum logic {
      OWN_IFU,
      OWN_EXEC
   } owner_t;

   // Value loaded into the latency counter in RD_ISSUE; RD_LATENCY is 1..7.
   localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

   state_t     state;
   owner_t     rd_owner;      // requester that owns the read in flight
   owner_t     last_served;   // last read requester granted (round-robin)
   logic [2:0] lat_cnt;       // cycles left before mem_rd_data is valid

   // One-cycle served-mask: the line just completed is ignored in the first
   // IDLE cycle afterwards so a requester still dropping req is not re-served.
   logic       mask_ifu;
   logic       mask_exec_rd;
   logic       mask_exec_wr;

   logic       ifu_live;
   logic       exec_rd_live;
   logic       exec_wr_live;
   logic       grant_ifu;

   // Masked request lines and the round-robin read choice used by IDLE.
   always_comb begin
      ifu_live     = ifu_rd_req  & ~mask_ifu;
      exec_rd_live = exec_rd_req & ~mask_exec_rd;
      exec_wr_live = exec_wr_req & ~mask_exec_wr;
      // On a read tie the requester that was not served last wins.
      grant_ifu    = ifu_live & (~exec_rd_live | (last_served == OWN_EXEC));
   end

   // Sequencer FSM with all outputs, latches and arbitration state registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: address/data output registers are cleared as well, because
         // every output must read 0 after reset, not just the strobes.
         state         <= IDLE;
         rd_owner      <= OWN_IFU;
         last_served   <= OWN_EXEC;
         lat_cnt       <= '0;
         mask_ifu      <= 1'b0;
         mask_exec_rd  <= 1'b0;
         mask_exec_wr  <= 1'b0;
         ifu_rd_data   <= '0;
         ifu_rd_valid  <= 1'b0;
         exec_rd_data  <= '0;
         exec_rd_valid <= 1'b0;
         exec_wr_done  <= 1'b0;
         mem_rd_req    <= 1'b0;
         mem_rd_addr   <= '0;
         mem_wr_req    <= 1'b0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
         busy          <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults make every strobe and pulse a single
         // cycle; a state below overrides them only on the cycle it fires.
         mem_rd_req    <= 1'b0;
         mem_wr_req    <= 1'b0;
         ifu_rd_valid  <= 1'b0;
         exec_rd_valid <= 1'b0;
         exec_wr_done  <= 1'b0;

         case (state)
            IDLE: begin
               // The mask only covers the first IDLE cycle after a completion.
               mask_ifu     <= 1'b0;
               mask_exec_rd <= 1'b0;
               mask_exec_wr <= 1'b0;
               if (exec_wr_live) begin
                  // Write has priority, so a same-cycle read sees the new word.
                  mem_wr_req  <= 1'b1;
                  mem_wr_addr <= exec_wr_addr;
                  mem_wr_data <= exec_wr_data;
                  busy        <= 1'b1;
                  state       <= WR_ISSUE;
               end else if (ifu_live | exec_rd_live) begin
                  mem_rd_req  <= 1'b1;
                  mem_rd_addr <= grant_ifu ? ifu_rd_addr : exec_rd_addr;
                  rd_owner    <= grant_ifu ? OWN_IFU : OWN_EXEC;
                  last_served <= grant_ifu ? OWN_IFU : OWN_EXEC;
                  busy        <= 1'b1;
                  state       <= RD_ISSUE;
               end
            end

            RD_ISSUE: begin
               lat_cnt <= LAT_LOAD;
               state   <= RD_WAIT;
            end

            RD_WAIT: begin
               if (lat_cnt == 3'd0) begin
                  // Memory data is valid in this cycle; hand it to the owner.
                  if (rd_owner == OWN_IFU) begin
                     ifu_rd_data  <= mem_rd_data;
                     ifu_rd_valid <= 1'b1;
                  end else begin
                     exec_rd_data  <= mem_rd_data;
                     exec_rd_valid <= 1'b1;
                  end
                  state <= RD_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            RD_RESP: begin
               mask_ifu     <= (rd_owner == OWN_IFU);
               mask_exec_rd <= (rd_owner == OWN_EXEC);
               busy         <= 1'b0;
               state        <= IDLE;
            end

            WR_ISSUE: begin
               exec_wr_done <= 1'b1;
               state        <= WR_RESP;
            end

            WR_RESP: begin
               mask_exec_wr <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// tb_pdp8_mem_arbiter
// Two arbiters (RD_LATENCY 1 and 3), each with its own memory device and a
// transaction-timeline model that predicts every output cycle by cycle from
// the grant rules; directed sequences add hand-computed literal expectations.

`timescale 1ns/1ps

module tb_pdp8_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 12;
   localparam int NI = 2;    // instance 0: RD_LATENCY=1, instance 1: RD_LATENCY=3
   localparam int NS = 16;   // timeline slots, larger than the longest look-ahead

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          reset         [NI];
   logic          ifu_rd_req    [NI];
   logic [AW-1:0] ifu_rd_addr   [NI];
   logic [DW-1:0] ifu_rd_data   [NI];
   logic          ifu_rd_valid  [NI];
   logic          exec_rd_req   [NI];
   logic [AW-1:0] exec_rd_addr  [NI];
   logic [DW-1:0] exec_rd_data  [NI];
   logic          exec_rd_valid [NI];
   logic          exec_wr_req   [NI];
   logic [AW-1:0] exec_wr_addr  [NI];
   logic [DW-1:0] exec_wr_data  [NI];
   logic          exec_wr_done  [NI];
   logic          mem_rd_req    [NI];
   logic [AW-1:0] mem_rd_addr   [NI];
   logic [DW-1:0] mem_rd_data   [NI];
   logic          mem_wr_req    [NI];
   logic [AW-1:0] mem_wr_addr   [NI];
   logic [DW-1:0] mem_wr_data   [NI];
   logic          busy          [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      pdp8_mem_arbiter #(
         .ADDR_WIDTH(AW),
         .DATA_WIDTH(DW),
         .RD_LATENCY(g == 0 ? 1 : 3)
      ) u_dut (
         .clk          (clk),
         .reset        (reset[g]),
         .ifu_rd_req   (ifu_rd_req[g]),
         .ifu_rd_addr  (ifu_rd_addr[g]),
         .ifu_rd_data  (ifu_rd_data[g]),
         .ifu_rd_valid (ifu_rd_valid[g]),
         .exec_rd_req  (exec_rd_req[g]),
         .exec_rd_addr (exec_rd_addr[g]),
         .exec_rd_data (exec_rd_data[g]),
         .exec_rd_valid(exec_rd_valid[g]),
         .exec_wr_req  (exec_wr_req[g]),
         .exec_wr_addr (exec_wr_addr[g]),
         .exec_wr_data (exec_wr_data[g]),
         .exec_wr_done (exec_wr_done[g]),
         .mem_rd_req   (mem_rd_req[g]),
         .mem_rd_addr  (mem_rd_addr[g]),
         .mem_rd_data  (mem_rd_data[g]),
         .mem_wr_req   (mem_wr_req[g]),
         .mem_wr_addr  (mem_wr_addr[g]),
         .mem_wr_data  (mem_wr_data[g]),
         .busy         (busy[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Initial memory contents: a few hand-picked words, a pattern elsewhere.
   function automatic logic [DW-1:0] init_word(input int a);
      logic [AW-1:0] aw;
      aw = AW'(a);
      case (aw)
         12'o0200: return 12'o7300;
         12'o0201: return 12'o2525;
         12'o0400: return 12'o4321;
         default:  return aw ^ 12'o5252;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Comparison bookkeeping
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Memory device: data for a strobe in cycle c is presented in c+latency.
   // ------------------------------------------------------------------
   logic [DW-1:0] dev_mem  [NI][4096];
   bit            dev_pend [NI][NS];
   logic [AW-1:0] dev_addr [NI][NS];

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (mem_rd_req[k] === 1'b1) begin
            dev_pend[k][(cyc + lat_of(k)) % NS] = 1'b1;
            dev_addr[k][(cyc + lat_of(k)) % NS] = mem_rd_addr[k];
         end
         if (mem_wr_req[k] === 1'b1)
            dev_mem[k][mem_wr_addr[k]] = mem_wr_data[k];
      end
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < NI; k++) begin
         if (dev_pend[k][cyc % NS])
            mem_rd_data[k] = dev_mem[k][dev_addr[k][cyc % NS]];
         else
            mem_rd_data[k] = 12'o6666;   // garbage outside the data-valid cycle
         dev_pend[k][cyc % NS] = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Reference model: a timeline of expected outputs per future cycle.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic          busy;
      logic          rd;
      logic          wr;
      logic          iv;
      logic          ev;
      logic          done;
      logic          iset;
      logic          eset;
      logic [AW-1:0] rd_addr;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;
      logic [DW-1:0] idat;
      logic [DW-1:0] edat;
   } slot_t;

   localparam int LINE_NONE = 0;
   localparam int LINE_IFU  = 1;
   localparam int LINE_ERD  = 2;
   localparam int LINE_WR   = 3;

   slot_t         tl        [NI][NS];
   logic [DW-1:0] ref_mem   [NI][4096];
   logic [DW-1:0] cur_idat  [NI];
   logic [DW-1:0] cur_edat  [NI];
   int            free_at   [NI];
   int            mask_cyc  [NI];
   int            mask_line [NI];
   bit            last_exec [NI];
   bit            armed     [NI];

   slot_t         sl;
   int            m_line;
   bit            want_w, want_i, want_e, pick_i;
   logic [AW-1:0] g_addr;
   int            lat;

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         // Compare this cycle's outputs with the timeline.
         sl = tl[k][cyc % NS];
         if (armed[k]) begin
            if (sl.iset) cur_idat[k] = sl.idat;
            if (sl.eset) cur_edat[k] = sl.edat;
            check($sformatf("k%0d busy", k),          busy[k],          sl.busy);
            check($sformatf("k%0d mem_rd_req", k),    mem_rd_req[k],    sl.rd);
            check($sformatf("k%0d mem_wr_req", k),    mem_wr_req[k],    sl.wr);
            check($sformatf("k%0d ifu_rd_valid", k),  ifu_rd_valid[k],  sl.iv);
            check($sformatf("k%0d exec_rd_valid", k), exec_rd_valid[k], sl.ev);
            check($sformatf("k%0d exec_wr_done", k),  exec_wr_done[k],  sl.done);
            check($sformatf("k%0d ifu_rd_data", k),   ifu_rd_data[k],   cur_idat[k]);
            check($sformatf("k%0d exec_rd_data", k),  exec_rd_data[k],  cur_edat[k]);
            if (sl.rd)
               check($sformatf("k%0d mem_rd_addr", k), mem_rd_addr[k], sl.rd_addr);
            if (sl.wr) begin
               check($sformatf("k%0d mem_wr_addr", k), mem_wr_addr[k], sl.wr_addr);
               check($sformatf("k%0d mem_wr_data", k), mem_wr_data[k], sl.wr_data);
            end
         end
         tl[k][cyc % NS] = '0;

         // Advance the model with this cycle's inputs.
         if (reset[k] === 1'b1) begin
            for (int j = 0; j < NS; j++) tl[k][j] = '0;
            tl[k][(cyc + 1) % NS].iset = 1'b1;   // data outputs read 0 next cycle
            tl[k][(cyc + 1) % NS].eset = 1'b1;
            free_at[k]   = cyc + 1;
            mask_cyc[k]  = -1;
            mask_line[k] = LINE_NONE;
            last_exec[k] = 1'b1;
            armed[k]     = 1'b1;
         end else if (armed[k] && cyc >= free_at[k]) begin
            m_line = (cyc == mask_cyc[k]) ? mask_line[k] : LINE_NONE;
            want_w = (exec_wr_req[k] === 1'b1) && (m_line != LINE_WR);
            want_i = (ifu_rd_req[k]  === 1'b1) && (m_line != LINE_IFU);
            want_e = (exec_rd_req[k] === 1'b1) && (m_line != LINE_ERD);
            if (want_w) begin
               tl[k][(cyc + 1) % NS].wr      = 1'b1;
               tl[k][(cyc + 1) % NS].wr_addr = exec_wr_addr[k];
               tl[k][(cyc + 1) % NS].wr_data = exec_wr_data[k];
               tl[k][(cyc + 1) % NS].busy    = 1'b1;
               tl[k][(cyc + 2) % NS].busy    = 1'b1;
               tl[k][(cyc + 2) % NS].done    = 1'b1;
               ref_mem[k][exec_wr_addr[k]]   = exec_wr_data[k];
               free_at[k]   = cyc + 3;
               mask_cyc[k]  = cyc + 3;
               mask_line[k] = LINE_WR;
            end else if (want_i || want_e) begin
               pick_i = want_i && (!want_e || last_exec[k]);
               g_addr = pick_i ? ifu_rd_addr[k] : exec_rd_addr[k];
               lat    = lat_of(k);
               tl[k][(cyc + 1) % NS].rd      = 1'b1;
               tl[k][(cyc + 1) % NS].rd_addr = g_addr;
               for (int j = 1; j <= 2 + lat; j++) tl[k][(cyc + j) % NS].busy = 1'b1;
               if (pick_i) begin
                  tl[k][(cyc + 2 + lat) % NS].iv   = 1'b1;
                  tl[k][(cyc + 2 + lat) % NS].iset = 1'b1;
                  tl[k][(cyc + 2 + lat) % NS].idat = ref_mem[k][g_addr];
               end else begin
                  tl[k][(cyc + 2 + lat) % NS].ev   = 1'b1;
                  tl[k][(cyc + 2 + lat) % NS].eset = 1'b1;
                  tl[k][(cyc + 2 + lat) % NS].edat = ref_mem[k][g_addr];
               end
               last_exec[k] = !pick_i;
               free_at[k]   = cyc + 3 + lat;
               mask_cyc[k]  = cyc + 3 + lat;
               mask_line[k] = pick_i ? LINE_IFU : LINE_ERD;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse(input int k);
      tick();
      reset[k] = 1'b1;
      tick();
      reset[k] = 1'b0;
      tick();
   endtask

   int n_done;
   int who[$];
   int when[$];
   int strobes[$];
   int voff[$];

   initial begin
      for (int k = 0; k < NI; k++) begin
         reset[k]        = 1'b1;
         ifu_rd_req[k]   = 1'b0;
         ifu_rd_addr[k]  = '0;
         exec_rd_req[k]  = 1'b0;
         exec_rd_addr[k] = '0;
         exec_wr_req[k]  = 1'b0;
         exec_wr_addr[k] = '0;
         exec_wr_data[k] = '0;
         armed[k]        = 1'b0;
         cur_idat[k]     = '0;
         cur_edat[k]     = '0;
         free_at[k]      = 0;
         mask_cyc[k]     = -1;
         mask_line[k]    = LINE_NONE;
         last_exec[k]    = 1'b1;
         for (int j = 0; j < NS; j++) begin
            tl[k][j]       = '0;
            dev_pend[k][j] = 1'b0;
            dev_addr[k][j] = '0;
         end
         for (int a = 0; a < 4096; a++) begin
            dev_mem[k][a] = init_word(a);
            ref_mem[k][a] = init_word(a);
         end
      end
      repeat (3) tick();
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      tick();

      // Single IFU fetch, latency 1.
      tick();
      ifu_rd_req[0]  = 1'b1;
      ifu_rd_addr[0] = 12'o0200;
      @(negedge clk);
      check("t1 busy before grant", busy[0], 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) ifu_rd_req[0] = 1'b0;
         @(negedge clk);
         check($sformatf("t1 busy c%0d", i), busy[0], (i <= 3) ? 1 : 0);
         check($sformatf("t1 mem_rd_req c%0d", i), mem_rd_req[0], (i == 1) ? 1 : 0);
         check($sformatf("t1 ifu_rd_valid c%0d", i), ifu_rd_valid[0], (i == 3) ? 1 : 0);
         if (i == 1) check("t1 mem_rd_addr", mem_rd_addr[0], 12'o0200);
         if (i == 3) check("t1 ifu_rd_data", ifu_rd_data[0], 12'o7300);
      end

      // Both readers held together: IFU, EXEC, IFU, EXEC, one every 4 cycles.
      reset_pulse(0);
      tick();
      ifu_rd_req[0]   = 1'b1;
      ifu_rd_addr[0]  = 12'o0300;
      exec_rd_req[0]  = 1'b1;
      exec_rd_addr[0] = 12'o0301;
      n_done = 0;
      for (int i = 0; i < 40 && n_done < 4; i++) begin
         @(negedge clk);
         if (mem_rd_req[0] === 1'b1) strobes.push_back(int'(mem_rd_addr[0]));
         if (ifu_rd_valid[0] === 1'b1) begin who.push_back(0); when.push_back(cyc); n_done++; end
         if (exec_rd_valid[0] === 1'b1) begin who.push_back(1); when.push_back(cyc); n_done++; end
         if (n_done < 4) tick();
      end
      tick();
      ifu_rd_req[0]  = 1'b0;
      exec_rd_req[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_rd_req[0] === 1'b1) strobes.push_back(int'(mem_rd_addr[0]));
         tick();
      end
      check("t2 completions", n_done, 4);
      check("t2 strobe count", strobes.size(), 4);
      for (int i = 0; i < who.size(); i++)
         check($sformatf("t2 owner #%0d", i), who[i], i % 2);
      for (int i = 1; i < when.size(); i++)
         check($sformatf("t2 spacing #%0d", i), when[i] - when[i-1], 4);
      for (int i = 0; i < strobes.size(); i++)
         check($sformatf("t2 strobe addr #%0d", i), strobes[i], (i % 2 == 0) ? 12'o0300 : 12'o0301);

      // Same-cycle write and read to one address: write first, read sees it.
      tick();
      exec_wr_req[0]  = 1'b1;
      exec_wr_addr[0] = 12'o0050;
      exec_wr_data[0] = 12'o1234;
      exec_rd_req[0]  = 1'b1;
      exec_rd_addr[0] = 12'o0050;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 3) exec_wr_req[0] = 1'b0;
         if (i == 7) exec_rd_req[0] = 1'b0;
         @(negedge clk);
         check($sformatf("t3 mem_wr_req c%0d", i), mem_wr_req[0], (i == 1) ? 1 : 0);
         check($sformatf("t3 exec_wr_done c%0d", i), exec_wr_done[0], (i == 2) ? 1 : 0);
         check($sformatf("t3 mem_rd_req c%0d", i), mem_rd_req[0], (i == 4) ? 1 : 0);
         check($sformatf("t3 exec_rd_valid c%0d", i), exec_rd_valid[0], (i == 6) ? 1 : 0);
         if (i == 1) begin
            check("t3 mem_wr_addr", mem_wr_addr[0], 12'o0050);
            check("t3 mem_wr_data", mem_wr_data[0], 12'o1234);
         end
         if (i == 6) check("t3 exec_rd_data", exec_rd_data[0], 12'o1234);
      end

      // Latency 3, address changed after grant has no effect.
      tick();
      exec_rd_req[1]  = 1'b1;
      exec_rd_addr[1] = 12'o0400;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 2) exec_rd_addr[1] = 12'o0777;
         if (i == 6) exec_rd_req[1] = 1'b0;
         @(negedge clk);
         check($sformatf("t4 mem_rd_req c%0d", i), mem_rd_req[1], (i == 1) ? 1 : 0);
         check($sformatf("t4 exec_rd_valid c%0d", i), exec_rd_valid[1], (i == 5) ? 1 : 0);
         if (i == 1) check("t4 mem_rd_addr", mem_rd_addr[1], 12'o0400);
         if (i == 5) check("t4 exec_rd_data", exec_rd_data[1], 12'o4321);
      end

      // Reset during RD_WAIT drops the read; a later fetch is served normally.
      tick();
      ifu_rd_req[0]  = 1'b1;
      ifu_rd_addr[0] = 12'o0200;
      tick();
      tick();
      reset[0]      = 1'b1;
      ifu_rd_req[0] = 1'b0;
      @(negedge clk);
      check("t5 busy in RD_WAIT", busy[0], 1);
      tick();
      reset[0] = 1'b0;
      @(negedge clk);
      check("t5 busy after reset", busy[0], 0);
      check("t5 mem_rd_req after reset", mem_rd_req[0], 0);
      check("t5 mem_rd_addr after reset", mem_rd_addr[0], 0);
      check("t5 mem_wr_req after reset", mem_wr_req[0], 0);
      check("t5 mem_wr_addr after reset", mem_wr_addr[0], 0);
      check("t5 mem_wr_data after reset", mem_wr_data[0], 0);
      check("t5 ifu_rd_valid after reset", ifu_rd_valid[0], 0);
      check("t5 ifu_rd_data after reset", ifu_rd_data[0], 0);
      check("t5 exec_rd_valid after reset", exec_rd_valid[0], 0);
      check("t5 exec_rd_data after reset", exec_rd_data[0], 0);
      check("t5 exec_wr_done after reset", exec_wr_done[0], 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         @(negedge clk);
         check($sformatf("t5 no stray valid c%0d", i), ifu_rd_valid[0], 0);
      end
      tick();
      ifu_rd_req[0]  = 1'b1;
      ifu_rd_addr[0] = 12'o0201;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) ifu_rd_req[0] = 1'b0;
         @(negedge clk);
         check($sformatf("t5 refetch valid c%0d", i), ifu_rd_valid[0], (i == 3) ? 1 : 0);
         if (i == 3) check("t5 refetch data", ifu_rd_data[0], 12'o2525);
      end

      // IFU alone, held for 12 cycles: served every 5 cycles.
      tick();
      ifu_rd_req[0]  = 1'b1;
      ifu_rd_addr[0] = 12'o0202;
      for (int i = 0; i < 18; i++) begin
         if (i > 0) tick();
         if (i == 12) ifu_rd_req[0] = 1'b0;
         @(negedge clk);
         if (ifu_rd_valid[0] === 1'b1) voff.push_back(i);
      end
      check("t6 valid count", voff.size(), 3);
      for (int i = 0; i < voff.size(); i++)
         check($sformatf("t6 valid offset #%0d", i), voff[i], 3 + 5 * i);

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a hang anywhere in the sequence.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
